seg7_scan_mux: RTL and testbench
================================

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter CBITS, default 10: digit dwell time is 2^CBITS clocks.
REQ-002 Parameter BLANK, default 2: inter-digit blanking time in clocks; legal range 1..255.
REQ-003 i_clk  input  1  single system clock; all state on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_digits  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 i_dp  input  4  decimal-point request per digit; bit n is digit n.
REQ-007 i_lzb  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 i_load  input  1  one-cycle strobe that captures i_digits and i_dp into the staging register.
REQ-009 o_ack  output  1  one-cycle pulse when staged data becomes the displayed data.
REQ-010 o_val  output  4  BCD value for the downstream BCD-to-7-segment decoder.
REQ-011 o_dec  output  1  decimal-point bit for the downstream decoder.
REQ-012 o_an  output  4  active-low digit anode enables.
REQ-013 o_digit  output  2  index of the digit currently presented.
REQ-014 o_frame  output  1  one-cycle pulse at the start of each frame.

Function
REQ-015 FSM states: BLANK and DWELL; per-phase counter cnt; digit index dig cycles 0,1,2,3,0 with wrap.
REQ-016 BLANK: cnt runs 0..BLANK-1, o_an=4'b1111; at cnt=BLANK-1, go to DWELL with cnt=0.
REQ-017 DWELL: cnt runs 0..2^CBITS-1, o_an bit dig low (unless blanked per REQ-022); at terminal count, dig increments mod 4 and FSM goes to BLANK with cnt=0.
REQ-018 On every BLANK entry, o_val, o_dec and o_digit register the new digit's display-register nibble, dp bit and index; they are stable throughout that BLANK and the following DWELL.
REQ-019 Frame length is 4*(BLANK+2^CBITS) clocks; o_frame pulses on the cycle BLANK is entered with dig=0.
REQ-020 i_load writes the staging register and sets pending; a later i_load before transfer overwrites the staging register; only one o_ack results.
REQ-021 On BLANK entry with dig=0 and pending=1: staging copies to the display register, o_ack pulses that same cycle, and pending clears. o_val/o_dec in that cycle already reflect the new data. An i_load in that same cycle re-sets pending with the new data, which transfers in the next frame.
REQ-022 Leading-zero blanking: if i_lzb=1, digit n (n=3..1) is blanked when its nibble and all higher nibbles are 0 and its dp bit is 0. A blanked digit keeps o_an=4'b1111 during DWELL. Digit 0 is never blanked.
REQ-023 Nibble values 10..15 pass through unmodified; decoding them is the decoder's concern.
REQ-024 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-025 While i_rst=1: FSM=BLANK, cnt=0, dig=0, display and staging registers=0, pending=0.
REQ-026 While i_rst=1, outputs are: o_an=4'b1111, o_val=0, o_dec=0, o_digit=0, o_ack=0, o_frame=0.
REQ-027 Reset asserted mid-frame or mid-load returns the block to the REQ-025/REQ-026 state immediately; the pending load is discarded and no o_ack is issued.
REQ-028 After deassertion, the first clock is cycle 0 of BLANK for digit 0; o_frame does not pulse for this post-reset frame start.

Verification (CBITS=2, BLANK=1; frame = 20 clocks)
REQ-029 Reset release, no load: o_an sequence is 1111 x1, 1110 x4, 1111 x1, 1101 x4, 1111 x1, 1011 x4, 1111 x1, 0111 x4, then repeats. o_val stays 0. o_frame pulses at clock 20.
REQ-030 i_load at clock 3 with i_digits=16'h1234, i_dp=4'b0100: o_ack pulses exactly once, at clock 20. During the next frame o_val reads 4,3,2,1 and o_dec=1 only for digit 2.
REQ-031 Two loads, 16'h1111 at clock 5 then 16'h2222 at clock 9: a single o_ack at clock 20 and display shows 2222.
REQ-032 i_lzb=1, data 16'h0050, dp=0: digits 3 and 2 are blanked (o_an=1111 in their DWELL); digit 1 shows 5; digit 0 shows 0. With dp=4'b1000, digit 3 is lit showing 0 with o_dec=1.
REQ-033 i_rst asserted at clock 12 with a load pending: outputs reset asynchronously; after release, no o_ack occurs and o_val stays 0 for a full frame.
REQ-034 Chained with the BCD7 decoder, count 16'h9876: decoder seg output matches the 9,8,7,6 patterns during each respective DWELL.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment scan controller.
// Cycles through digits 0..3, each slot being a BLANK-clock blanking phase
// (all anodes off) followed by a 2^CBITS-clock dwell with one anode enabled.
// New data is staged by i_load and moved to the display register only at
// the start of a frame, so a frame never shows a mix of old and new digits.
//
// Ports:
//   i_clk     system clock, all state on rising edge
//   i_rst     asynchronous active-high reset
//   i_digits  four BCD nibbles, [3:0] is digit 0 (rightmost)
//   i_dp      decimal-point request per digit
//   i_lzb     leading-zero blanking enable
//   i_load    strobe capturing i_digits/i_dp into the staging register
//   o_ack     pulse when staged data becomes displayed data
//   o_val     BCD nibble for the downstream decoder
//   o_dec     decimal-point bit for the downstream decoder
//   o_an      active-low anode enables
//   o_digit   index of the digit currently presented
//   o_frame   pulse at the start of each frame (not after reset)
module seg7_scan_mux #(
  parameter int unsigned CBITS = 10,
  parameter int unsigned BLANK = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  input  logic        i_load,
  output logic        o_ack,
  output logic [3:0]  o_val,
  output logic        o_dec,
  output logic [3:0]  o_an,
  output logic [1:0]  o_digit,
  output logic        o_frame
);

  // Counter must hold both the blanking count (up to 254) and the dwell count.
  localparam int unsigned CW = (CBITS > 8) ? CBITS : 8;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'((64'd1 << CBITS) - 64'd1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    dig;
  logic [1:0]    dig_nx;

  logic [15:0]   disp;
  logic [3:0]    disp_dp;
  logic [15:0]   disp_nx;
  logic [3:0]    dp_nx;
  logic [15:0]   stage;
  logic [3:0]    stage_dp;
  logic          pending;

  logic          enter_blank;
  logic          xfer;
  logic [3:0]    lead_zero;
  logic          blanked;
  logic [3:0]    an_nx;

  // Phase sequencing: blanking phase, then dwell, then next digit.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CW'(1);
    dig_nx      = dig;
    enter_blank = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = S_DWELL;
          cnt_nx   = '0;
        end
      end
      S_DWELL: begin
        if (cnt == DWELL_LAST) begin
          state_nx    = S_BLANK;
          cnt_nx      = '0;
          dig_nx      = dig + 2'd1;
          enter_blank = 1'b1;
        end
      end
    endcase
  end

  // Staged data lands in the display register as digit 0's blanking starts.
  always_comb begin
    xfer    = enter_blank && (dig_nx == 2'd0) && pending;
    disp_nx = xfer ? stage    : disp;
    dp_nx   = xfer ? stage_dp : disp_dp;
  end

  // lead_zero[n]: nibble n and every nibble above it are zero.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_nx[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_nx[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_nx[7:4] == 4'd0);
    // Digit 0 is never blanked, so lead_zero[0] stays 0.
    blanked      = i_lzb && lead_zero[dig_nx] && !dp_nx[dig_nx];
    an_nx        = 4'b1111;
    if ((state_nx == S_DWELL) && !blanked) begin
      an_nx = ~(4'b0001 << dig_nx);
    end
  end

  // State and registered outputs; outputs track the next-state view so they
  // line up with the phase they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_BLANK;
      cnt      <= '0;
      dig      <= 2'd0;
      disp     <= 16'd0;
      disp_dp  <= 4'd0;
      stage    <= 16'd0;
      stage_dp <= 4'd0;
      pending  <= 1'b0;
      o_ack    <= 1'b0;
      o_val    <= 4'd0;
      o_dec    <= 1'b0;
      o_an     <= 4'b1111;
      o_digit  <= 2'd0;
      o_frame  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dig      <= dig_nx;
      disp     <= disp_nx;
      disp_dp  <= dp_nx;
      if (i_load) begin
        stage    <= i_digits;
        stage_dp <= i_dp;
      end
      // A load on the transfer edge re-arms pending for the next frame.
      pending  <= i_load || (pending && !xfer);
      o_ack    <= xfer;
      o_val    <= disp_nx[{dig_nx, 2'b00} +: 4];
      o_dec    <= dp_nx[dig_nx];
      o_an     <= an_nx;
      o_digit  <= dig_nx;
      o_frame  <= enter_blank && (dig_nx == 2'd0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (CBITS=2, BLANK=1, 20-clock frame).
// Expected outputs come from a cycle-position model: the cycle number since
// reset release gives slot and phase by division, and a small staging/display
// model tracks which data is on show.
module tb_seg7_scan_mux;

  localparam int unsigned CBITS = 2;
  localparam int unsigned BLANK = 1;
  localparam int SLOT  = BLANK + (1 << CBITS);
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_digits = 16'd0;
  logic [3:0]  i_dp = 4'd0;
  logic        i_lzb = 1'b0;
  logic        i_load = 1'b0;
  logic        o_ack;
  logic [3:0]  o_val;
  logic        o_dec;
  logic [3:0]  o_an;
  logic [1:0]  o_digit;
  logic        o_frame;

  seg7_scan_mux #(.CBITS(CBITS), .BLANK(BLANK)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_digits(i_digits),
    .i_dp    (i_dp),
    .i_lzb   (i_lzb),
    .i_load  (i_load),
    .o_ack   (o_ack),
    .o_val   (o_val),
    .o_dec   (o_dec),
    .o_an    (o_an),
    .o_digit (o_digit),
    .o_frame (o_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model state
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_stage;
  logic [3:0]  m_stage_dp;
  logic        m_pending;
  logic        m_ack;
  // Inputs driven during the previous cycle (sampled on the edge into t)
  logic        p_load;
  logic [15:0] p_digits;
  logic [3:0]  p_dp;
  logic        p_lzb;
  logic        cur_lzb;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %0h exp %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_clear();
    m_disp = 16'd0; m_dp = 4'd0; m_stage = 16'd0; m_stage_dp = 4'd0;
    m_pending = 1'b0; m_ack = 1'b0;
    p_load = 1'b0; p_digits = 16'd0; p_dp = 4'd0; p_lzb = 1'b0;
  endtask

  // Advance the model across one clock edge.
  task automatic model_edge();
    t = t + 1;
    m_ack = ((t % FRAME) == 0) && m_pending;
    if (m_ack) begin
      m_disp = m_stage;
      m_dp   = m_stage_dp;
    end
    if (p_load) begin
      m_stage    = p_digits;
      m_stage_dp = p_dp;
      m_pending  = 1'b1;
    end else if (m_ack) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int pos;
    int slot;
    int ph;
    logic [3:0] nib;
    logic blank;
    logic [3:0] ean;
    pos  = t % FRAME;
    slot = pos / SLOT;
    ph   = pos % SLOT;
    nib  = 4'(m_disp >> (4 * slot));
    blank = p_lzb && (slot > 0) && ((m_disp >> (4 * slot)) == 16'd0) && !m_dp[slot];
    ean  = (ph == 0 || blank) ? 4'hF : ~(4'(1) << slot);
    chk("an",    16'(o_an),    16'(ean));
    chk("val",   16'(o_val),   16'(nib));
    chk("dec",   16'(o_dec),   16'(m_dp[slot]));
    chk("digit", 16'(o_digit), 16'(slot));
    chk("frame", 16'(o_frame), 16'((pos == 0) && (t > 0)));
    chk("ack",   16'(o_ack),   16'(m_ack));
  endtask

  // Drive one cycle of inputs, cross the edge, check the new cycle.
  task automatic step(input logic load, input logic [15:0] digits,
                      input logic [3:0] dp, input logic lzb);
    i_load = load; i_digits = digits; i_dp = dp; i_lzb = lzb;
    p_load = load; p_digits = digits; p_dp = dp; p_lzb = lzb;
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic idle(input int n, input logic lzb);
    repeat (n) step(1'b0, 16'd0, 4'd0, lzb);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},    16'(o_an),    16'hF);
    chk({tag, "_val"},   16'(o_val),   16'h0);
    chk({tag, "_dec"},   16'(o_dec),   16'h0);
    chk({tag, "_digit"}, 16'(o_digit), 16'h0);
    chk({tag, "_ack"},   16'(o_ack),   16'h0);
    chk({tag, "_frame"}, 16'(o_frame), 16'h0);
  endtask

  // Assert reset asynchronously, hold over edges with a load, release just
  // after an edge so the following cycle is cycle 0.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    i_load = 1'b1; i_digits = 16'($urandom); i_dp = 4'hF;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_load = 1'b0; i_digits = 16'd0; i_dp = 4'd0;
    t = 0;
    model_clear();
    check_outputs();
  endtask

  task automatic rand_step();
    logic [15:0] d;
    logic [3:0]  dp;
    logic        ld;
    for (int k = 0; k < 4; k++) begin
      d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
    ld = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 15) == 0) cur_lzb = ~cur_lzb;
    step(ld, d, dp, cur_lzb);
  endtask

  initial begin
    model_clear();
    cur_lzb = 1'b0;
    @(posedge clk);

    // Free-running scan with no data: two frames
    do_reset();
    idle(40, 1'b0);

    // Single load at clock 3, displayed from clock 20
    do_reset();
    idle(3, 1'b0);
    step(1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(40, 1'b0);

    // Two loads before transfer: last one wins, one ack
    do_reset();
    idle(5, 1'b0);
    step(1'b1, 16'h1111, 4'b0000, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 16'h2222, 4'b0000, 1'b0);
    idle(40, 1'b0);

    // Leading-zero blanking, without and with a dp on digit 3
    do_reset();
    step(1'b1, 16'h0050, 4'b0000, 1'b1);
    idle(40, 1'b1);
    step(1'b1, 16'h0050, 4'b1000, 1'b1);
    idle(40, 1'b1);

    // Reset mid-frame with a load pending: load discarded
    do_reset();
    idle(3, 1'b0);
    step(1'b1, 16'h8765, 4'b0011, 1'b0);
    idle(8, 1'b0);
    do_reset();
    idle(25, 1'b0);

    // Loads on and right after the transfer edge move to the next frame
    do_reset();
    idle(4, 1'b0);
    step(1'b1, 16'hAAAA, 4'b0001, 1'b0);
    idle(14, 1'b0);
    step(1'b1, 16'hBBBB, 4'b0010, 1'b0);
    step(1'b1, 16'h9876, 4'b0000, 1'b0);
    idle(45, 1'b0);

    // Randomized traffic, including values 10..15 and lzb toggling
    do_reset();
    repeat (1500) rand_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
